risc_execute_unit: RTL



---
 rtl/risc_execute_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/risc_execute_unit.sv
// rtl/risc_execute_unit.sv - execute/writeback stage with single-cycle ALU and iterative shift-add MUL
module risc_execute_unit #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [1:0]      dest,
  input  logic [BITS-1:0] opA,
  input  logic [BITS-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic            Write,
  output logic [1:0]      DestAddr,
  output logic [BITS-1:0] DestData,
  output logic            zero,
  output logic            carry
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;
  localparam int         CW       = $clog2(BITS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

  state_t            state_q;
  logic              busy_q, write_q;
  logic [1:0]        addr_q, dest_q;
  logic [BITS-1:0]   data_q;
  logic              zero_q, carry_q;
  logic [2*BITS-1:0] acc_q, mcand_q;
  logic [BITS-1:0]   mplier_q;
  logic [CW-1:0]     cnt_q;

  logic [BITS:0]     alu_d;
  logic [2*BITS-1:0] acc_d;

  // Bit BITS of alu_d is the carry/borrow; the zero-extended subtract yields borrow there.
  always_comb begin
    alu_d = '0;
    unique case (op)
      OP_ADD:   alu_d = {1'b0, opA} + {1'b0, opB};
      OP_SUB:   alu_d = {1'b0, opA} - {1'b0, opB};
      OP_AND:   alu_d = {1'b0, opA & opB};
      OP_OR:    alu_d = {1'b0, opA | opB};
      OP_XOR:   alu_d = {1'b0, opA ^ opB};
      OP_SHL:   alu_d = {1'b0, opA << opB[3:0]};
      OP_PASSB: alu_d = {1'b0, opB};
      default:  alu_d = '0;
    endcase
  end

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      dest_q   <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            dest_q <= dest;
            busy_q <= 1'b1;
            if (op == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= {{BITS{1'b0}}, opA};
              mplier_q <= opB;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              data_q  <= alu_d[BITS-1:0];
              carry_q <= alu_d[BITS];
              zero_q  <= (alu_d[BITS-1:0] == '0);
              addr_q  <= dest;
              write_q <= 1'b1;
              state_q <= S_WB;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(BITS - 1)) begin
            data_q  <= acc_d[BITS-1:0];
            carry_q <= |acc_d[2*BITS-1:BITS];
            zero_q  <= (acc_d[BITS-1:0] == '0);
            addr_q  <= dest_q;
            write_q <= 1'b1;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = write_q;
  assign Write    = write_q;
  assign DestAddr = addr_q;
  assign DestData = data_q;
  assign zero     = zero_q;
  assign carry    = carry_q;

endmodule
